// File: rtl/cycler_pkg.sv
// Shared types and constants for the vector checker: FSM states, the default
// full-adder/logic vector table and field helpers for the default 8-bit layout.
package cycler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    localparam int unsigned DefaultDepth = 8;
    localparam int unsigned DefaultVecW  = 8;

    // {A,B,cin} -> {sum, carry, and, or, xor}
    function automatic logic [7:0] default_entry(input int unsigned idx);
        logic [7:0] v;
        case (idx)
            0:       v = 8'b000_00_000;
            1:       v = 8'b010_10_011;
            2:       v = 8'b100_10_011;
            3:       v = 8'b110_01_110;
            4:       v = 8'b001_10_000;
            5:       v = 8'b011_01_011;
            6:       v = 8'b101_01_011;
            7:       v = 8'b111_11_110;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] default_stim(input logic [7:0] vec);
        return vec[7:5];
    endfunction

    function automatic logic [4:0] default_exp(input logic [7:0] vec);
        return vec[4:0];
    endfunction

endpackage

// File: rtl/vector_table.sv
// DEPTH x VEC_W vector store: one write port, one registered read port.
// Contents survive reset; only the read register is cleared.
module vector_table
  import cycler_pkg::*;
#(
  parameter int unsigned VEC_W     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [VEC_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [VEC_W-1:0] rd_data_o
);

  localparam int unsigned ImgW = DEPTH * VEC_W;

  function automatic logic [ImgW-1:0] init_image();
    logic [ImgW-1:0] img;
    img = '0;
    if (INIT_FILE == "" && DEPTH == DefaultDepth && VEC_W == DefaultVecW) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        img[i*VEC_W +: VEC_W] = VEC_W'(default_entry(i));
      end
    end
    return img;
  endfunction

  // Flat storage so the power-up image can come from a single function.
  logic [ImgW-1:0]  mem_q = init_image();
  logic [VEC_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[VEC_W*int'(wr_addr_i) +: VEC_W] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= mem_q[VEC_W*int'(rd_addr_i) +: VEC_W];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/vector_checker.sv
// Stimulus/check sequencer: issues table vectors over valid/ready, scores the
// response against the expected field with a per-vector timeout.
module vector_checker
    import cycler_pkg::*;
#(
    parameter int unsigned VEC_W     = 8,
    parameter int unsigned STIM_W    = 3,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_W     = 16,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned RESP_W   = VEC_W - STIM_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_en_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [VEC_W-1:0]  wr_data_i,
    output logic [STIM_W-1:0] stim_o,
    output logic              stim_valid_o,
    input  logic              stim_ready_i,
    input  logic              resp_valid_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW-1:0]     cur_idx_o,
    output logic [CNT_W-1:0]  pass_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [AW-1:0]     first_err_idx_o,
    output logic              err_seen_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     cur_idx_q, cur_idx_d;
    logic              loop_q, loop_d;
    logic              stop_q, stop_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [AW-1:0]     first_err_q, first_err_d;
    logic              err_seen_q, err_seen_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              tbl_wr_en;
    logic              tbl_rd_en;
    logic [AW-1:0]     tbl_rd_addr;
    logic [VEC_W-1:0]  tbl_rd_data;
    logic [RESP_W-1:0] exp_val;
    logic              last_idx;
    logic [AW-1:0]     next_idx;

    // The table read register doubles as the stim/exp holding register.
    vector_table #(
        .VEC_W     (VEC_W),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (tbl_wr_en),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (tbl_rd_en),
        .rd_addr_i (tbl_rd_addr),
        .rd_data_o (tbl_rd_data)
    );

    assign stim_o   = tbl_rd_data[VEC_W-1 -: STIM_W];
    assign exp_val  = tbl_rd_data[RESP_W-1:0];
    assign last_idx = (cur_idx_q == AW'(DEPTH - 1));
    assign next_idx = last_idx ? '0 : cur_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        loop_d      = loop_q;
        stop_d      = stop_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        timer_d     = timer_q;
        tbl_wr_en   = 1'b0;
        tbl_rd_en   = 1'b0;
        tbl_rd_addr = cur_idx_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d     = StIssue;
                    cur_idx_d   = '0;
                    loop_d      = loop_en_i;
                    stop_d      = 1'b0;
                    pass_d      = '0;
                    err_d       = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                    tbl_rd_en   = 1'b1;
                    tbl_rd_addr = '0;
                end else begin
                    tbl_wr_en = wr_en_i;
                end
            end
            StIssue: begin
                if (stop_i) stop_d = 1'b1;
                if (stim_ready_i) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (stop_i) stop_d = 1'b1;
                timer_d = timer_q + 1'b1;
                // A response on the expiry cycle still counts as a response.
                if (resp_valid_i || timer_q == TW'(TIMEOUT - 1)) begin
                    if (resp_valid_i && resp_i == exp_val) begin
                        if (pass_q != '1) pass_d = pass_q + 1'b1;
                    end else begin
                        if (err_q != '1) err_d = err_q + 1'b1;
                        if (!err_seen_q) begin
                            err_seen_d  = 1'b1;
                            first_err_d = cur_idx_q;
                        end
                    end
                    if (stop_q || stop_i || (last_idx && !loop_q)) begin
                        state_d = StDone;
                        stop_d  = 1'b0;
                    end else begin
                        state_d     = StIssue;
                        cur_idx_d   = next_idx;
                        tbl_rd_en   = 1'b1;
                        tbl_rd_addr = next_idx;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_idx_q   <= '0;
            loop_q      <= 1'b0;
            stop_q      <= 1'b0;
            pass_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            loop_q      <= loop_d;
            stop_q      <= stop_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            timer_q     <= timer_d;
        end
    end

    assign stim_valid_o    = (state_q == StIssue);
    assign busy_o          = (state_q == StIssue) || (state_q == StWait);
    assign done_o          = (state_q == StDone);
    assign cur_idx_o       = cur_idx_q;
    assign pass_count_o    = pass_q;
    assign err_count_o     = err_q;
    assign first_err_idx_o = first_err_q;
    assign err_seen_o      = err_seen_q;

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: ALU response model plus a stimulus scoreboard.
module tb_vector_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop_en, wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  stim;
    logic        stim_valid;
    logic        stim_ready;
    logic        resp_valid;
    logic [4:0]  resp;
    logic        busy, done;
    logic [2:0]  cur_idx;
    logic [15:0] pass_count, err_count;
    logic [2:0]  first_err_idx;
    logic        err_seen;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] idx;
        logic [2:0] stim;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    logic [7:0] tb_mem [8];
    bit         corrupt [8];
    int         drop_idx   = -1;
    bit         ready_rand = 1'b0;
    int         hs_count   = 0;

    vector_checker dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .stop_i          (stop),
        .loop_en_i       (loop_en),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .stim_o          (stim),
        .stim_valid_o    (stim_valid),
        .stim_ready_i    (stim_ready),
        .resp_valid_i    (resp_valid),
        .resp_i          (resp),
        .busy_o          (busy),
        .done_o          (done),
        .cur_idx_o       (cur_idx),
        .pass_count_o    (pass_count),
        .err_count_o     (err_count),
        .first_err_idx_o (first_err_idx),
        .err_seen_o      (err_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] alu(input logic [2:0] s);
        logic a, b, c;
        a = s[2]; b = s[1]; c = s[0];
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c), a & b, a | b, a ^ b};
    endfunction

    // ALU model and handshake scoreboard, all on the falling edge.
    always @(negedge clk) begin
        stim_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (busy && !stim_valid && int'(cur_idx) != drop_idx) begin
            resp_valid = 1'b1;
            resp       = alu(stim) ^ (corrupt[cur_idx] ? 5'b00001 : 5'b00000);
        end else begin
            resp_valid = 1'b0;
            resp       = 5'b0;
        end
        if (stim_valid && stim_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: handshake idx=%0d stim=%b with nothing expected",
                         cur_idx, stim);
            end else begin
                e = sb_q.pop_front();
                if (stim !== e.stim || cur_idx !== e.idx) begin
                    failures++;
                    $display("FAIL sb_stim: got idx=%0d stim=%b, want idx=%0d stim=%b",
                             cur_idx, stim, e.idx, e.stim);
                end
            end
        end
    end

    task automatic launch(input bit lp, input int nvec);
        exp_t x;
        for (int i = 0; i < nvec; i++) begin
            x.idx  = 3'(i % 8);
            x.stim = tb_mem[i % 8][7:5];
            sb_q.push_back(x);
        end
        @(negedge clk);
        start   = 1'b1;
        loop_en = lp;
        @(negedge clk);
        start   = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = done;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({stim_valid, busy, done, err_seen} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, want 0000", {stim_valid, busy, done, err_seen});
        end
        checks++;
        if ({stim, cur_idx, first_err_idx, pass_count, err_count} !== 41'b0) begin
            failures++;
            $display("FAIL reset_values: stim=%b idx=%0d fe=%0d pass=%0d err=%0d, want all 0",
                     stim, cur_idx, first_err_idx, pass_count, err_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_run;
        bit ok;
        launch(1'b0, 8);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd8 || err_count !== 16'd0 || err_seen !== 1'b0) begin
            failures++;
            $display("FAIL clean_run: done=%b pass=%0d err=%0d seen=%b, want 1 8 0 0",
                     done, pass_count, err_count, err_seen);
        end
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clean_run_drain: left=%0d busy=%b, want 0 0", sb_q.size(), busy);
        end
    endtask

    task automatic test_mismatch;
        bit ok;
        corrupt[5] = 1'b1;
        launch(1'b0, 8);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd7 || err_count !== 16'd1 || err_seen !== 1'b1
            || first_err_idx !== 3'd5) begin
            failures++;
            $display("FAIL mismatch_one: pass=%0d err=%0d seen=%b fe=%0d, want 7 1 1 5",
                     pass_count, err_count, err_seen, first_err_idx);
        end
        corrupt[6] = 1'b1;
        launch(1'b0, 8);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd6 || err_count !== 16'd2 || first_err_idx !== 3'd5) begin
            failures++;
            $display("FAIL mismatch_two: pass=%0d err=%0d fe=%0d, want 6 2 5",
                     pass_count, err_count, first_err_idx);
        end
        corrupt[5] = 1'b0;
        corrupt[6] = 1'b0;
    endtask

    task automatic test_timeout;
        int n = 0;
        int wait_cycles = 0;
        drop_idx = 2;
        launch(1'b0, 8);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (busy && !stim_valid && cur_idx == 3'd2) wait_cycles++;
        end
        checks++;
        if (wait_cycles != 15) begin
            failures++;
            $display("FAIL timeout_len: got %0d wait cycles, want 15", wait_cycles);
        end
        checks++;
        if (!done || pass_count !== 16'd7 || err_count !== 16'd1 || first_err_idx !== 3'd2) begin
            failures++;
            $display("FAIL timeout_score: done=%b pass=%0d err=%0d fe=%0d, want 1 7 1 2",
                     done, pass_count, err_count, first_err_idx);
        end
        drop_idx = -1;
    endtask

    task automatic test_loop_stop;
        bit ok;
        int n = 0;
        int base;
        base = hs_count;
        launch(1'b1, 32);
        while (!(hs_count >= base + 20 && busy && !stim_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(50, ok);
        checks++;
        if (!ok || pass_count !== 16'd20 || err_count !== 16'd0 || cur_idx !== 3'd3) begin
            failures++;
            $display("FAIL loop_stop: done=%b pass=%0d err=%0d idx=%0d, want 1 20 0 3",
                     done, pass_count, err_count, cur_idx);
        end
        sb_q.delete();
    endtask

    task automatic test_write;
        bit ok;
        launch(1'b0, 8);
        write_entry(3'd4, 8'hFF);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd8 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL write_busy: pass=%0d err=%0d, want 8 0", pass_count, err_count);
        end
        write_entry(3'd4, 8'hFF);
        tb_mem[4] = 8'hFF;
        launch(1'b0, 8);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd7 || err_count !== 16'd1 || first_err_idx !== 3'd4) begin
            failures++;
            $display("FAIL write_idle: pass=%0d err=%0d fe=%0d, want 7 1 4",
                     pass_count, err_count, first_err_idx);
        end
    endtask

    task automatic test_reset_midrun;
        bit ok;
        int n = 0;
        ready_rand = 1'b1;
        launch(1'b0, 8);
        while (!(busy && !stim_valid && cur_idx == 3'd1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(busy && !stim_valid)) begin
            failures++;
            $display("FAIL midrun_reach: busy=%b valid=%b, want WAIT", busy, stim_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stim_valid, busy, done, err_seen, stim, cur_idx, first_err_idx} !== 13'b0
            || pass_count !== 16'd0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset: valid=%b busy=%b done=%b stim=%b idx=%0d pass=%0d err=%0d, want all 0",
                     stim_valid, busy, done, stim, cur_idx, pass_count, err_count);
        end
        @(negedge clk);
        ready_rand = 1'b0;
        rst_n      = 1'b1;
        sb_q.delete();
        @(negedge clk);
        launch(1'b0, 8);
        wait_done(100, ok);
        checks++;
        if (!ok || pass_count !== 16'd7 || err_count !== 16'd1 || first_err_idx !== 3'd4) begin
            failures++;
            $display("FAIL midrun_replay: pass=%0d err=%0d fe=%0d, want 7 1 4",
                     pass_count, err_count, first_err_idx);
        end
    endtask

    initial begin
        tb_mem = '{8'b000_00_000, 8'b010_10_011, 8'b100_10_011, 8'b110_01_110,
                   8'b001_10_000, 8'b011_01_011, 8'b101_01_011, 8'b111_11_110};
        for (int i = 0; i < 8; i++) corrupt[i] = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        loop_en    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'd0;
        stim_ready = 1'b1;
        resp_valid = 1'b0;
        resp       = 5'd0;
        test_reset();
        test_clean_run();
        test_mismatch();
        test_timeout();
        test_loop_stop();
        test_write();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
